// File: rtl/wb_write_arbiter_if.sv
// Writeback arbiter bus bundle: execute/memory result ports, register file
// write port, decode read/forwarding ports and the sticky overflow flag.
// The slave modport is the arbiter side, the master modport is its environment.
interface wb_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] dstE_i;
    logic [DATA_W-1:0] valE_i;
    logic [ADDR_W-1:0] dstM_i;
    logic [DATA_W-1:0] valM_i;
    logic              wr_ready_o;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic [ADDR_W-1:0] srcA_i;
    logic [ADDR_W-1:0] srcB_i;
    logic [DATA_W-1:0] rf_rdataA_i;
    logic [DATA_W-1:0] rf_rdataB_i;
    logic [DATA_W-1:0] valA_o;
    logic [DATA_W-1:0] valB_o;
    logic              drop_err_o;

    modport slave (
        input  dstE_i, valE_i, dstM_i, valM_i,
        input  srcA_i, srcB_i, rf_rdataA_i, rf_rdataB_i,
        output wr_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        output valA_o, valB_o, drop_err_o
    );

    modport master (
        output dstE_i, valE_i, dstM_i, valM_i,
        output srcA_i, srcB_i, rf_rdataA_i, rf_rdataB_i,
        input  wr_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        input  valA_o, valB_o, drop_err_o
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: accepts up to two register writes per cycle (E older,
// M newer) into an in-order FIFO, retires one per cycle to a single-port
// register file and forwards queued values to the decode read ports.
// Optional macro WB_COALESCE_EN: when E and M target the same register in
// one cycle only the M write is queued.
module wb_write_arbiter #(
    parameter int                DATA_W = 64,
    parameter int                ADDR_W = 4,
    parameter logic [ADDR_W-1:0] NREG   = ADDR_W'(4'hF),
    parameter int                DEPTH  = 4
) (
    input logic              clk_i,
    input logic              rst_i,
    wb_write_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              drop_err;

    logic              e_req;
    logic              m_req;
    logic              ready;
    logic              pop;
    logic              e_push;
    logic              m_push;
    logic [1:0]        n_push;
    logic [PTR_W-1:0]  m_slot;
    logic [PTR_W-1:0]  fwd_idx;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;

    assign m_req = (bus.dstM_i != NREG);
`ifdef WB_COALESCE_EN
    // A same-cycle E write to M's register would be overwritten anyway
    assign e_req = (bus.dstE_i != NREG) && !(m_req && (bus.dstE_i == bus.dstM_i));
`else
    assign e_req = (bus.dstE_i != NREG);
`endif

    // Readiness looks at the current occupancy only, so two slots are always
    // guaranteed regardless of whether the head retires this cycle
    assign ready  = (count <= CNT_W'(DEPTH - 2));
    assign pop    = (count != '0);
    assign e_push = e_req && ready;
    assign m_push = m_req && ready;
    assign n_push = {1'b0, e_push} + {1'b0, m_push};
    assign m_slot = e_push ? (wr_ptr + PTR_W'(1)) : wr_ptr;

    // FIFO storage, pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            if (e_push) begin
                mem_addr[wr_ptr] <= bus.dstE_i;
                mem_data[wr_ptr] <= bus.valE_i;
            end
            if (m_push) begin
                mem_addr[m_slot] <= bus.dstM_i;
                mem_data[m_slot] <= bus.valM_i;
            end
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(n_push) - CNT_W'(pop);
            if ((e_req || m_req) && !ready) begin
                drop_err <= 1'b1;
            end
        end
    end

    // Forwarding: walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        val_a   = bus.rf_rdataA_i;
        val_b   = bus.rf_rdataB_i;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (mem_addr[fwd_idx] == bus.srcA_i) begin
                    val_a = mem_data[fwd_idx];
                end
                if (mem_addr[fwd_idx] == bus.srcB_i) begin
                    val_b = mem_data[fwd_idx];
                end
            end
        end
        if (bus.srcA_i == NREG) begin
            val_a = '0;
        end
        if (bus.srcB_i == NREG) begin
            val_b = '0;
        end
    end

    assign bus.wr_ready_o = ready;
    assign bus.rf_we_o    = pop;
    assign bus.rf_waddr_o = pop ? mem_addr[rd_ptr] : '0;
    assign bus.rf_wdata_o = pop ? mem_data[rd_ptr] : '0;
    assign bus.valA_o     = val_a;
    assign bus.valB_o     = val_b;
    assign bus.drop_err_o = drop_err;
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Sits between the execute/memory result buses and a single-write-port register file.
- Each cycle it accepts up to two writebacks (E port, M port), queues them in a small in-order FIFO and retires one per cycle to the register file.
- Forwards pending queued values to decode reads so the decode stage never sees stale data.

Parameters:
- DATA_W, 64, register data width.
- ADDR_W, 4, register address width.
- NREG, 4'hF, "no register" address. A write to NREG is ignored; a read from NREG returns 0.
- DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous, active-high.
- dstE_i  in  ADDR_W  E-port destination; NREG = no write.
- valE_i  in  DATA_W  E-port data (ALU result).
- dstM_i  in  ADDR_W  M-port destination; NREG = no write.
- valM_i  in  DATA_W  M-port data (memory load).
- wr_ready_o  out  1  high when at least 2 FIFO slots are free.
- rf_we_o  out  1  register file write enable.
- rf_waddr_o  out  ADDR_W  register file write address.
- rf_wdata_o  out  DATA_W  register file write data.
- srcA_i  in  ADDR_W  decode read address A.
- srcB_i  in  ADDR_W  decode read address B.
- rf_rdataA_i  in  DATA_W  register file raw read data for srcA_i.
- rf_rdataB_i  in  DATA_W  register file raw read data for srcB_i.
- valA_o  out  DATA_W  forwarded read value A.
- valB_o  out  DATA_W  forwarded read value B.
- drop_err_o  out  1  sticky overflow error.

Behaviour:
- Reset: FIFO empty, pointers 0, count 0, drop_err_o=0. Consequently rf_we_o=0, wr_ready_o=1, and rf_waddr_o/rf_wdata_o=0.
- Push: a port pushes when its dst != NREG and wr_ready_o=1, sampled at posedge.
  - Both ports valid: E occupies the older slot, M the newer, so M's value ultimately wins for an equal dst.
- wr_ready_o = (DEPTH - count >= 2). It depends on current count only, not on the same-cycle pop.
- Overflow: a push attempt while wr_ready_o=0 is discarded and sets drop_err_o=1 until reset. FIFO contents are unaffected.
- Pop/write port:
  - rf_we_o = (count != 0). rf_waddr_o/rf_wdata_o are the FIFO head, driven combinationally from registered state.
  - The head pops at every posedge where rf_we_o=1; the register file always accepts.
  - Latency: a lone push on an empty FIFO appears on the write port the cycle after it is sampled.
- Count update: count_next = count + pushes(0..2) - pop(0/1). Simultaneous push and pop are legal, including at count = DEPTH-2.
- Pointers wrap modulo DEPTH.
- Forwarding (combinational) for each read port independently:
  - src == NREG -> 0.
  - Otherwise, the youngest valid FIFO entry (including the head being written this cycle) whose address equals src supplies the data.
  - No match -> rf_rdata*_i.
  - Same-cycle inputs dstE_i/dstM_i are not forwarded; they become visible the following cycle.
- Reset mid-operation: all queued writes are discarded. No rf_we_o pulse occurs in the cycle after the reset sample.

Optional Feature:
- Macro: WB_COALESCE_EN.
  - Defined: when dstE_i == dstM_i != NREG in the same cycle, only the M entry is enqueued (1 slot); E is dropped silently. wr_ready_o is unchanged (still >=2 free).
  - Undefined: both entries are enqueued, E then M.

Test Plan:
- Reset, then idle -> rf_we_o=0, wr_ready_o=1, drop_err_o=0, valA_o=rf_rdataA_i for srcA_i=3.
- Cycle 1: dstE_i=2/valE_i=0x11, dstM_i=5/valM_i=0x22 -> cycle 2 write (2,0x11), cycle 3 write (5,0x22), cycle 4 rf_we_o=0.
- Push dstE_i=dstM_i=7 (E=0xA, M=0xB), srcA_i=7, rf_rdataA_i=0x0.
  - Without macro: next cycle valA_o=0xB; writes (7,0xA) then (7,0xB).
  - With WB_COALESCE_EN: single write (7,0xB).
- Push two writes per cycle for 3 cycles (DEPTH=4) -> wr_ready_o drops to 0 once count reaches 3; further push attempts set drop_err_o=1; the FIFO still drains the accepted entries in order.
- srcB_i=NREG with a matching pending entry at addr 0xF impossible (NREG never enqueued) -> valB_o=0 always.
- Assert rst_i while count=3 -> next cycle rf_we_o=0, wr_ready_o=1, drop_err_o=0.
